// File: rtl/wb_fib_master_pkg.sv
// Shared definitions for the Fibonacci peripheral Wishbone initiator.
// Register window offsets, identification constant, FSM encoding and counter sizing.
// No logic; imported by the interface-facing master and its users.
package wb_fib_master_pkg;

    // Peripheral register window (byte offsets, word aligned)
    localparam logic [5:0] REG_NR       = 6'h00;
    localparam logic [5:0] REG_ID       = 6'h04;
    localparam logic [5:0] REG_CTRL     = 6'h08;
    localparam logic [5:0] REG_STATUS   = 6'h0C;
    localparam logic [5:0] REG_IRQ      = 6'h10;
    localparam logic [5:0] REG_FIB      = 6'h14;
    localparam logic [5:0] REG_DATA_IN  = 6'h18;
    localparam logic [5:0] REG_DATA_OUT = 6'h1C;
    localparam logic [5:0] REG_PANIC    = 6'h20;

    // Value returned by the peripheral's ID register ("Fibo")
    localparam logic [31:0] CTRL_ID = 32'h4669626f;

    // Width of the bus wait / ack counters; bounds TIMEOUT to 255
    localparam int TMO_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Full 33-bit bus address for a register offset inside the peripheral window
    function automatic logic [32:0] bus_addr(input logic [27:0] base, input logic [5:0] off);
        return {base, 5'b00000} + {27'b0, off};
    endfunction

endpackage

// File: rtl/wb_fib_master_if.sv
// Wishbone classic bus between the Fibonacci initiator and the peripheral slave port.
// Pure wiring, no latency.
// Flow control is the Wishbone cyc/stb/ack handshake; the slave stalls by withholding ack.
interface wb_fib_master_if;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [32:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        output wbm_cyc_o,
        output wbm_stb_o,
        output wbm_we_o,
        output wbm_sel_o,
        output wbm_adr_o,
        output wbm_dat_o,
        input  wbm_ack_i,
        input  wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o,
        input  wbm_stb_o,
        input  wbm_we_o,
        input  wbm_sel_o,
        input  wbm_adr_o,
        input  wbm_dat_o,
        output wbm_ack_i,
        output wbm_dat_i
    );

endinterface

// File: rtl/wb_fib_master.sv
// Wishbone classic initiator: one local command -> one bus cycle -> one response (data or timeout error).
// Latency: write 3 cycles accept-to-rsp_valid, read 3+RD_WAIT; all outputs registered.
// Backpressure: cmd_ready only in IDLE; rsp_valid held until rsp_ready. Optional WB_FIB_MASTER_AUTOPOLL_EN adds background polling.
module wb_fib_master
    import wb_fib_master_pkg::*;
#(
    parameter logic [27:0] BASE_ADDRESS = 28'h0300000,
    parameter int unsigned RD_WAIT      = 1,
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned POLL_DIV     = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [5:0]      cmd_addr,
    input  logic [31:0]     cmd_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic            rsp_err,
    wb_fib_master_if.master wbm,
    output logic [29:0]     poll_value
);

    localparam logic [TMO_W-1:0] RD_WAIT_C = TMO_W'(RD_WAIT);
    localparam logic [TMO_W:0]   TIMEOUT_C = (TMO_W + 1)'(TIMEOUT);
    localparam logic [TMO_W:0]   ONE_W1    = (TMO_W + 1)'(1);

    // Reject configurations the 8-bit wait counter or the poll divider cannot honour
    if ((TIMEOUT < RD_WAIT + 1) || (TIMEOUT > (1 << TMO_W) - 1) || (POLL_DIV < 2)) begin : g_bad_cfg
        $error("wb_fib_master: invalid RD_WAIT/TIMEOUT/POLL_DIV combination");
    end

    state_t             state_q, state_d;
    logic               cyc_q, we_q;
    logic [3:0]         sel_q;
    logic [32:0]        adr_q;
    logic [31:0]        dat_q;
    logic [TMO_W-1:0]   wait_cnt_q;
    logic [TMO_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic               start_cmd, start_poll;
    logic               bus_done, bus_tmo;
    logic               tmo_hit;
    logic               poll_fire;
    logic               is_poll;

    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;

    // This BUS cycle is the TIMEOUT-th one spent waiting
    assign tmo_hit = ({1'b0, wait_cnt_q} + ONE_W1) == TIMEOUT_C;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_d    = state_q;
        start_cmd  = 1'b0;
        start_poll = 1'b0;
        bus_done   = 1'b0;
        bus_tmo    = 1'b0;
        ack_cnt_d  = ack_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // A real command always beats a pending poll
                if (cmd_valid && cmd_ready) begin
                    start_cmd = 1'b1;
                    state_d   = ST_BUS;
                end else if (poll_fire) begin
                    start_poll = 1'b1;
                    state_d    = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wbm.wbm_ack_i) begin
                    // Reads need RD_WAIT+1 consecutive ack cycles because slave data is registered
                    if (!we_q && (ack_cnt_q != RD_WAIT_C)) begin
                        ack_cnt_d = ack_cnt_q + TMO_W'(1);
                    end else begin
                        bus_done = 1'b1;
                    end
                end else begin
                    ack_cnt_d = '0;
                end
                // Completion in the same cycle as the limit still counts as success
                if (!bus_done && tmo_hit) begin
                    bus_tmo = 1'b1;
                end
                if (bus_done || bus_tmo) begin
                    state_d = is_poll ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus-side registers: launch, hold and tear down the Wishbone cycle
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            adr_q      <= '0;
            dat_q      <= '0;
            wait_cnt_q <= '0;
            ack_cnt_q  <= '0;
        end else if (start_cmd || start_poll) begin
            cyc_q      <= 1'b1;
            we_q       <= start_cmd & cmd_we;
            sel_q      <= 4'hF;
            adr_q      <= bus_addr(BASE_ADDRESS, start_cmd ? cmd_addr : REG_FIB);
            dat_q      <= start_cmd ? cmd_data : 32'h0;
            wait_cnt_q <= '0;
            ack_cnt_q  <= '0;
        end else if (state_q == ST_BUS) begin
            if (bus_done || bus_tmo) begin
                cyc_q <= 1'b0;
                we_q  <= 1'b0;
                sel_q <= 4'h0;
                adr_q <= '0;
                dat_q <= '0;
            end
            wait_cnt_q <= wait_cnt_q + TMO_W'(1);
            ack_cnt_q  <= ack_cnt_d;
        end
    end

    // Local-side registers: command readiness and the held response
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            cmd_ready <= (state_d == ST_IDLE);
            rsp_valid <= (state_d == ST_RESP);
            if ((bus_done || bus_tmo) && !is_poll) begin
                rsp_data <= (bus_done && !we_q) ? wbm.wbm_dat_i : 32'h0;
                rsp_err  <= bus_tmo;
            end
        end
    end

`ifdef WB_FIB_MASTER_AUTOPOLL_EN
    localparam int PC_W = $clog2(POLL_DIV + 1);

    logic [PC_W-1:0] poll_cnt_q;
    logic            poll_pend_q;
    logic            is_poll_q;
    logic [29:0]     poll_value_q;
    logic            poll_wrap;

    assign poll_wrap  = (poll_cnt_q == PC_W'(POLL_DIV - 1));
    assign poll_fire  = poll_pend_q & cmd_ready & ~cmd_valid;
    assign is_poll    = is_poll_q;
    assign poll_value = poll_value_q;

    // Free-running divider; a missed poll stays pending until the next free IDLE cycle
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            poll_cnt_q   <= '0;
            poll_pend_q  <= 1'b0;
            is_poll_q    <= 1'b0;
            poll_value_q <= '0;
        end else begin
            poll_cnt_q <= poll_wrap ? '0 : poll_cnt_q + PC_W'(1);
            if (start_poll) begin
                poll_pend_q <= 1'b0;
            end
            if (poll_wrap) begin
                poll_pend_q <= 1'b1;
            end
            if (start_cmd) begin
                is_poll_q <= 1'b0;
            end else if (start_poll) begin
                is_poll_q <= 1'b1;
            end
            // A timed-out poll leaves the last good value in place
            if (is_poll_q && bus_done) begin
                poll_value_q <= wbm.wbm_dat_i[29:0];
            end
        end
    end
`else
    assign poll_fire  = 1'b0;
    assign is_poll    = 1'b0;
    assign poll_value = 30'b0;
`endif

endmodule

// File: tb/tb_wb_fib_master.sv
// Directed + randomized bench for wb_fib_master against a Fibonacci peripheral model.
// Latency of the peripheral: combinational ack, registered read data.
// Expected responses come from a register-map reference kept apart from the peripheral model.
module tb_wb_fib_master;

    localparam logic [27:0] BASE      = 28'h0300000;
    localparam logic [32:0] BASE_FULL = {BASE, 5'b00000};
    localparam logic [31:0] ID_VAL    = 32'h4669626f;

    logic        clk = 1'b0;
    logic        wb_rst_ni;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [29:0] poll_value;

    int n_vec = 0;
    int n_err = 0;
    int n_cyc, n_ack;

    wb_fib_master_if bus ();

    wb_fib_master #(
        .BASE_ADDRESS (BASE),
        .RD_WAIT      (1),
        .TIMEOUT      (255),
        .POLL_DIV     (16)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (wb_rst_ni),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .wbm        (bus.master),
        .poll_value (poll_value)
    );

    always #5 clk = ~clk;

    // ---------------- peripheral model ----------------
    logic        ack_en = 1'b0;
    logic        fib_run = 1'b0;
    logic [31:0] fib_a = 32'd1;
    logic [31:0] fib_b = 32'd2;
    logic [3:0]  fib_tick = 4'd0;
    logic [31:0] pmem [0:8] = '{default: 32'h0};
    logic [32:0] p_off;
    logic        p_hit;

    assign p_off = bus.wbm_adr_o - BASE_FULL;
    assign p_hit = (p_off <= 33'h20);
    assign bus.wbm_ack_i = bus.wbm_cyc_o & bus.wbm_stb_o & ack_en & p_hit;

    function automatic logic [31:0] p_read(input logic [5:0] o);
        case (o)
            6'h04:   return ID_VAL;
            6'h14:   return fib_a;
            6'h1C:   return pmem[6];
            default: return pmem[o[5:2]];
        endcase
    endfunction

    always @(posedge clk) begin
        bus.wbm_dat_i <= p_hit ? p_read(p_off[5:0]) : 32'h0;
        if (bus.wbm_ack_i && bus.wbm_we_o && p_off[5:0] != 6'h04 && p_off[5:0] != 6'h14 && p_off[5:0] != 6'h1C)
            pmem[p_off[5:2]] <= bus.wbm_dat_o;
        if (fib_run) begin
            fib_tick <= fib_tick + 4'd1;
            if (fib_tick == 4'd15) begin
                fib_a <= fib_b;
                fib_b <= fib_a + fib_b;
            end
        end
    end

    // ---------------- reference register map ----------------
    logic [31:0] ref_regs [int];

    function automatic logic [31:0] ref_get(input int o);
        return ref_regs.exists(o) ? ref_regs[o] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_read(input int o);
        if (o == 'h04) return ID_VAL;
        if (o == 'h1C) return ref_get('h18);
        return ref_get(o);
    endfunction

    task automatic ref_write(input int o, input logic [31:0] d);
        if (o != 'h04 && o != 'h14 && o != 'h1C) ref_regs[o] = d;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // amode: 0 ack never, 1 ack always, 2 ack randomly withheld
    task automatic do_cmd(input logic we, input logic [5:0] off, input logic [31:0] d, input int amode,
                          input int hold, input logic [31:0] exp_data, input logic exp_err);
        int          budget;
        logic [32:0] exp_adr;
        exp_adr   = BASE_FULL + {27'b0, off};
        ack_en    = 1'b1;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = off;
        cmd_data  = d;
        budget    = 0;
        while (cmd_ready !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("accept_wait", 72'(budget < 200), 72'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cyc  = 0;
        n_ack  = 0;
        budget = 0;
        while (rsp_valid !== 1'b1 && budget < 400) begin
            ack_en = (amode == 1) || (amode == 2 && $urandom_range(0, 3) != 0);
            #1;
            if (bus.wbm_cyc_o === 1'b1) begin
                n_cyc++;
                if (bus.wbm_ack_i) n_ack++;
                check("bus_ctl", {bus.wbm_stb_o, bus.wbm_sel_o, bus.wbm_we_o, bus.wbm_adr_o},
                                 {1'b1, 4'hF, we, exp_adr});
                if (we) check("bus_wdat", bus.wbm_dat_o, d);
                check("busy_cmd_ready", cmd_ready, 1'b0);
            end
            @(negedge clk);
            budget++;
        end
        check("rsp_wait", 72'(budget < 400), 72'd1);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", rsp_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_data", rsp_data, exp_data);
            check("hold_cmd_ready", cmd_ready, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ack_en    = 1'b1;
    endtask

    // Hard stop in case something wedges outside a bounded wait
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [5:0]  offs [8] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h18, 6'h1C, 6'h20};
    logic [5:0]  r_off;
    logic        r_we;
    logic [31:0] r_dat, r_exp;
    logic [29:0] prev_poll;
    int          changes;

    initial begin
        wb_rst_ni = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 6'h0;
        cmd_data  = 32'h0;
        rsp_ready = 1'b0;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            check("rst_bus", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
                              bus.wbm_adr_o, bus.wbm_dat_o}, 72'd0);
            check("rst_rsp", {cmd_ready, rsp_valid, rsp_err, rsp_data}, 72'd0);
            check("rst_poll", poll_value, 30'd0);
        end
        wb_rst_ni = 1'b1;
        @(negedge clk);
        check("release_cmd_ready", cmd_ready, 1'b1);
        check("release_idle", {bus.wbm_cyc_o, rsp_valid}, 2'b00);

        // ID read: two ack cycles before the registered data is taken
        do_cmd(1'b0, 6'h04, 32'h0, 1, 0, ID_VAL, 1'b0);
        check("id_cyc_len", n_cyc, 2);
        check("id_ack_len", n_ack, 2);

        // Write then read back through the mirror register
        do_cmd(1'b1, 6'h18, 32'hA5A5_0001, 1, 0, 32'h0, 1'b0);
        ref_write('h18, 32'hA5A5_0001);
        check("wr_cyc_len", n_cyc, 1);
        do_cmd(1'b0, 6'h1C, 32'h0, 1, 0, 32'hA5A5_0001, 1'b0);
        check("rd_cyc_len", n_cyc, 2);

        // No ack at all: abort after TIMEOUT bus cycles
        do_cmd(1'b0, 6'h08, 32'h0, 0, 0, 32'h0, 1'b1);
        check("tmo_cyc_len", n_cyc, 255);

        // Response held while the consumer stalls
        do_cmd(1'b0, 6'h1C, 32'h0, 1, 10, 32'hA5A5_0001, 1'b0);

        // Random traffic with ack gaps
        for (int t = 0; t < 40; t++) begin
            r_off = offs[$urandom_range(0, 7)];
            r_we  = 1'($urandom_range(0, 1));
            r_dat = $urandom;
            r_exp = r_we ? 32'h0 : ref_read(int'(r_off));
            do_cmd(r_we, r_off, r_dat, 2, 0, r_exp, 1'b0);
            if (r_we) ref_write(int'(r_off), r_dat);
        end

        // Reset in the middle of a stalled bus cycle
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 6'h08;
        for (int b = 0; b < 200 && cmd_ready !== 1'b1; b++) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        ack_en    = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_cyc_active", bus.wbm_cyc_o, 1'b1);
        wb_rst_ni = 1'b0;
        @(negedge clk);
        check("mid_rst_drop", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_sel_o, rsp_valid, cmd_ready}, 72'd0);
        wb_rst_ni = 1'b1;
        ack_en    = 1'b1;
        @(negedge clk);
        check("mid_release", {cmd_ready, rsp_valid}, 2'b10);
        do_cmd(1'b0, 6'h1C, 32'h0, 1, 0, ref_read('h1C), 1'b0);

`ifdef WB_FIB_MASTER_AUTOPOLL_EN
        // Running Fibonacci register: polled value only ever grows and never raises rsp_valid
        fib_run   = 1'b1;
        prev_poll = poll_value;
        changes   = 0;
        repeat (400) begin
            @(negedge clk);
            check("poll_no_rsp", rsp_valid, 1'b0);
            check("poll_monotonic", 72'(poll_value >= prev_poll), 72'd1);
            if (poll_value != prev_poll) changes++;
            prev_poll = poll_value;
        end
        check("poll_updates", 72'(changes >= 10), 72'd1);
        // Commands still complete correctly while polling is active
        for (int t = 0; t < 8; t++) begin
            r_off = offs[$urandom_range(0, 7)];
            do_cmd(1'b0, r_off, 32'h0, 1, 0, ref_read(int'(r_off)), 1'b0);
        end
`else
        repeat (50) @(negedge clk);
        check("poll_tied_off", poll_value, 30'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
